// File: rtl/find_my_best.sv
// Neighbor search: reads a neighbor count and per-neighbor Q-values from memory,
// writes back the index and Q-value of the best neighbor. Define
// FMB_HOPS_TIEBREAK_EN to also read hop counts and break Q ties on fewer hops.
module find_my_best #(
    parameter logic [10:0] ADDR_NCOUNT = 11'h274,
    parameter logic [10:0] ADDR_QVAL   = 11'h052,
    parameter logic [10:0] ADDR_HOPS   = 11'h032,
    parameter logic [10:0] ADDR_BEST   = 11'h276,
    parameter int          MAX_NBR     = 16
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        en,
    input  logic        start,
    input  logic [15:0] data_in,
    output logic [10:0] address,
    output logic [15:0] data_out,
    output logic        wr_en,
    output logic        done,
    output logic [2:0]  state_dbg
);

    // Memory handshake: address/data_out/wr_en are registered; data_in is the
    // read data for whatever address is presented during the same cycle, and a
    // write takes effect in every cycle wr_en is high.
`ifdef FMB_HOPS_TIEBREAK_EN
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_NCOUNT = 3'd1,
        RD_QVAL   = 3'd2,
        RD_HOPS   = 3'd3,
        WR_BEST   = 3'd4,
        WR_BESTQ  = 3'd5,
        DONE      = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_NCOUNT = 3'd1,
        RD_QVAL   = 3'd2,
        WR_BEST   = 3'd4,
        WR_BESTQ  = 3'd5,
        DONE      = 3'd6
    } state_t;
`endif

    state_t      state, state_n;
    logic [4:0]  i, i_n, i_inc;
    logic [4:0]  count, count_n;
    logic [15:0] best_idx, best_idx_n;
    logic [15:0] best_q, best_q_n;
    logic [10:0] address_n;
    logic [15:0] data_out_n;
    logic        wr_en_n, done_n;
    logic [15:0] cand_q;
    logic        better;
`ifdef FMB_HOPS_TIEBREAK_EN
    logic [15:0] best_hops, best_hops_n;
    logic [15:0] q_hold, q_hold_n;
`endif

    function automatic logic [10:0] tbl_addr(input logic [10:0] base, input logic [4:0] idx);
        return base + {5'd0, idx, 1'b0};
    endfunction

    assign i_inc     = i + 5'd1;
    assign state_dbg = state;

    // The first neighbor always wins (sentinel index); afterwards only a strictly
    // better candidate replaces, so ties keep the lower index.
    always_comb begin
`ifdef FMB_HOPS_TIEBREAK_EN
        cand_q = q_hold;
        better = (best_idx == 16'hFFFF) || (cand_q > best_q) ||
                 ((cand_q == best_q) && (data_in < best_hops));
`else
        cand_q = data_in;
        better = (best_idx == 16'hFFFF) || (cand_q > best_q);
`endif
    end

    always_comb begin
        state_n     = state;
        i_n         = i;
        count_n     = count;
        best_idx_n  = best_idx;
        best_q_n    = best_q;
        address_n   = address;
        data_out_n  = data_out;
        wr_en_n     = 1'b0;
        done_n      = 1'b0;
`ifdef FMB_HOPS_TIEBREAK_EN
        best_hops_n = best_hops;
        q_hold_n    = q_hold;
`endif
        if (state != IDLE && !en) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (en && start) begin
                        state_n     = RD_NCOUNT;
                        address_n   = ADDR_NCOUNT;
                        i_n         = 5'd0;
                        best_idx_n  = 16'hFFFF;
                        best_q_n    = 16'd0;
`ifdef FMB_HOPS_TIEBREAK_EN
                        best_hops_n = 16'hFFFF;
`endif
                    end
                end
                RD_NCOUNT: begin
                    if (data_in > 16'(MAX_NBR)) count_n = 5'(MAX_NBR);
                    else                        count_n = data_in[4:0];
                    if (count_n == 5'd0) begin
                        state_n    = WR_BEST;
                        address_n  = ADDR_BEST;
                        data_out_n = best_idx;
                        wr_en_n    = 1'b1;
                    end else begin
                        state_n   = RD_QVAL;
                        address_n = ADDR_QVAL;
                    end
                end
`ifdef FMB_HOPS_TIEBREAK_EN
                RD_QVAL: begin
                    q_hold_n  = data_in;
                    address_n = tbl_addr(ADDR_HOPS, i);
                    state_n   = RD_HOPS;
                end
                RD_HOPS: begin
`else
                RD_QVAL: begin
`endif
                    if (better) begin
                        best_idx_n  = {11'd0, i};
                        best_q_n    = cand_q;
`ifdef FMB_HOPS_TIEBREAK_EN
                        best_hops_n = data_in;
`endif
                    end
                    i_n = i_inc;
                    // Last neighbor: the write of the index must already see this compare.
                    if (i_inc == count) begin
                        state_n    = WR_BEST;
                        address_n  = ADDR_BEST;
                        data_out_n = better ? {11'd0, i} : best_idx;
                        wr_en_n    = 1'b1;
                    end else begin
                        state_n   = RD_QVAL;
                        address_n = tbl_addr(ADDR_QVAL, i_inc);
                    end
                end
                WR_BEST: begin
                    state_n    = WR_BESTQ;
                    address_n  = ADDR_BEST + 11'd2;
                    data_out_n = best_q;
                    wr_en_n    = 1'b1;
                end
                WR_BESTQ: begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end
                DONE: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            i         <= 5'd0;
            count     <= 5'd0;
            best_idx  <= 16'hFFFF;
            best_q    <= 16'd0;
            address   <= 11'd0;
            data_out  <= 16'd0;
            wr_en     <= 1'b0;
            done      <= 1'b0;
`ifdef FMB_HOPS_TIEBREAK_EN
            best_hops <= 16'hFFFF;
            q_hold    <= 16'd0;
`endif
        end else begin
            state     <= state_n;
            i         <= i_n;
            count     <= count_n;
            best_idx  <= best_idx_n;
            best_q    <= best_q_n;
            address   <= address_n;
            data_out  <= data_out_n;
            wr_en     <= wr_en_n;
            done      <= done_n;
`ifdef FMB_HOPS_TIEBREAK_EN
            best_hops <= best_hops_n;
            q_hold    <= q_hold_n;
`endif
        end
    end

endmodule

// File: tb/tb_find_my_best.sv
// Bench for find_my_best: memory model, write scoreboard, latency and abort checks.
module tb_find_my_best;

    localparam logic [10:0] A_BEST = 11'h276;
    localparam int W_NCOUNT = 'h274 >> 1;
    localparam int W_QVAL   = 'h052 >> 1;
    localparam int W_HOPS   = 'h032 >> 1;

    logic        clock = 1'b0;
    logic        rst, en, start;
    logic [15:0] data_in;
    logic [10:0] address;
    logic [15:0] data_out;
    logic        wr_en, done;
    logic [2:0]  state_dbg;

    logic [15:0] mem [0:1023];
    logic [26:0] exp_q [$];
    logic [10:0] max_q_addr;
    int n_vec = 0, n_err = 0, done_count = 0, wr_count = 0;

    find_my_best dut (
        .clock(clock), .rst(rst), .en(en), .start(start), .data_in(data_in),
        .address(address), .data_out(data_out), .wr_en(wr_en), .done(done),
        .state_dbg(state_dbg)
    );

    assign data_in = mem[address[10:1]];

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every write the DUT makes must match the head of exp_q.
    always @(negedge clock) begin
        if (done) done_count++;
        if (state_dbg == 3'd2 && address > max_q_addr) max_q_addr = address;
        if (wr_en) begin
            wr_count++;
            n_vec++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_write: observed addr %0h data %0h expected no write", address, data_out);
            end
            if (exp_q.size() != 0) check("write", {5'd0, address, data_out}, {5'd0, exp_q.pop_front()});
        end
    end

    function automatic void model(output logic [15:0] bi, output logic [15:0] bq, output int lat);
        int n;
        logic [15:0] q;
        logic bt;
`ifdef FMB_HOPS_TIEBREAK_EN
        logic [15:0] h, bh;
        bh = 16'hFFFF;
`endif
        n = (mem[W_NCOUNT] > 16) ? 16 : int'(mem[W_NCOUNT]);
        bi = 16'hFFFF;
        bq = 16'd0;
        for (int k = 0; k < n; k++) begin
            q = mem[W_QVAL + k];
`ifdef FMB_HOPS_TIEBREAK_EN
            h = mem[W_HOPS + k];
            bt = (bi == 16'hFFFF) || (q > bq) || (q == bq && h < bh);
            if (bt) bh = h;
`else
            bt = (bi == 16'hFFFF) || (q > bq);
`endif
            if (bt) begin
                bi = 16'(k);
                bq = q;
            end
        end
`ifdef FMB_HOPS_TIEBREAK_EN
        lat = 2 * n + 3;
`else
        lat = n + 3;
`endif
    endfunction

    task automatic run_search(input string tag, input bit extra_start);
        logic [15:0] bi, bq;
        int lat, k, d0, w0;
        model(bi, bq, lat);
        exp_q.push_back({A_BEST, bi});
        exp_q.push_back({A_BEST + 11'd2, bq});
        d0 = done_count;
        w0 = wr_count;
        @(negedge clock) start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (k = 1; k <= 200; k++) begin
            @(posedge clock);
            #1;
            if (extra_start && k == 2) start = 1'b1;
            if (k == 3) start = 1'b0;
            if (done) break;
        end
        start = 1'b0;
        check({tag, "_latency"}, k, lat);
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        check({tag, "_done_pulses"}, done_count - d0, 1);
        check({tag, "_write_count"}, wr_count - w0, 2);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic load(input int n, input int q0, input int q1, input int q2,
                        input int h0, input int h1, input int h2);
        mem[W_NCOUNT] = 16'(n);
        mem[W_QVAL]   = 16'(q0);
        mem[W_QVAL+1] = 16'(q1);
        mem[W_QVAL+2] = 16'(q2);
        mem[W_HOPS]   = 16'(h0);
        mem[W_HOPS+1] = 16'(h1);
        mem[W_HOPS+2] = 16'(h2);
    endtask

    initial begin
        int d0, w0, n;
        rst = 1'b1; en = 1'b0; start = 1'b0;
        for (int k = 0; k < 1024; k++) mem[k] = 16'd0;
        #12;
        check("rst_address", address, 0);
        check("rst_data_out", data_out, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_done", done, 0);
        check("rst_state", state_dbg, 0);
        @(negedge clock) rst = 1'b0;
        en = 1'b1;

        load(3, 5, 9, 7, 1, 1, 1);
        run_search("q_5_9_7", 1'b0);
        load(0, 5, 9, 7, 1, 1, 1);
        run_search("count_zero", 1'b0);
        load(2, 4, 4, 0, 3, 1, 0);
        run_search("q_tie_hops", 1'b0);

        // Count above the clamp: entries beyond 16 hold a value that would win if read.
        mem[W_NCOUNT] = 16'd20;
        for (int k = 0; k < 20; k++) begin
            mem[W_QVAL + k] = (k >= 16) ? 16'hFFFF : 16'($urandom_range(0, 1000));
            mem[W_HOPS + k] = 16'($urandom_range(0, 7));
        end
        max_q_addr = 11'd0;
        run_search("clamp_20", 1'b0);
        check("clamp_max_q_addr", max_q_addr, 11'h070);

        for (int r = 0; r < 4; r++) begin
            mem[W_NCOUNT] = 16'($urandom_range(1, 16));
            for (int k = 0; k < 16; k++) begin
                mem[W_QVAL + k] = 16'($urandom_range(0, 15));
                mem[W_HOPS + k] = 16'($urandom_range(0, 7));
            end
            run_search($sformatf("random_%0d", r), r == 1);
        end

        // Enable dropped while reading neighbor 1's Q-value.
        load(4, 1, 2, 3, 0, 0, 0);
        d0 = done_count;
        w0 = wr_count;
        @(negedge clock) start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
`ifdef FMB_HOPS_TIEBREAK_EN
        n = 3;
`else
        n = 2;
`endif
        repeat (n - 1) @(posedge clock);
        @(negedge clock) en = 1'b0;
        @(posedge clock);
        #1;
        check("en_drop_state", state_dbg, 0);
        check("en_drop_wr_en", wr_en, 0);
        repeat (2) @(posedge clock);
        @(negedge clock) en = 1'b1;
        repeat (8) @(posedge clock);
        @(negedge clock);
        #1;
        check("en_drop_no_done", done_count - d0, 0);
        check("en_drop_no_write", wr_count - w0, 0);

        // Reset while the index write is on the bus.
        load(0, 0, 0, 0, 0, 0, 0);
        @(negedge clock) start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        @(posedge clock);
        #1;
        check("pre_rst_wr_en", wr_en, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_wr_en", wr_en, 0);
        check("mid_rst_address", address, 0);
        check("mid_rst_data_out", data_out, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_state", state_dbg, 0);
        @(negedge clock);
        @(negedge clock) rst = 1'b0;
        load(3, 7, 7, 2, 5, 2, 0);
        run_search("after_rst", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
